// File: rtl/aes_ti_seq.sv
// Byte-serial sequencer around a threshold-implementation (masked) AES core:
// collects 16 shared plaintext/key bytes, feeds the core, gathers the ciphertext and drains it.
module aes_ti_seq #(
  parameter int NSHARES = 2,
  parameter int TIMEOUT = 300,
  parameter int REFRESH = 1
) (
  input  logic                 ClkxCI,
  input  logic                 RstxRI,
  input  logic                 InValidxSI,
  output logic                 InReadyxSO,
  input  logic [8*NSHARES-1:0] PTxDI,
  input  logic [7:0]           KxDI,
  input  logic [7:0]           RandxDI,
  output logic                 CoreStartxSO,
  output logic [8*NSHARES-1:0] CorePTxDO,
  output logic [7:0]           CoreKxDO,
  input  logic                 CoreDonexSI,
  input  logic [8*NSHARES-1:0] CoreCTxDI,
  output logic                 OutValidxSO,
  input  logic                 OutReadyxSI,
  output logic [8*NSHARES-1:0] CTxDO,
  output logic                 OutLastxSO,
  output logic                 ErrxSO
);

  localparam int SW = 8 * NSHARES;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] TONE  = TW'(1);

  typedef enum logic [2:0] {IDLE, LOAD, FEED, RUN, COLLECT, DRAIN} state_t;

  state_t        stateQ, stateD;
  logic [3:0]    idxQ, idxD;
  logic [TW-1:0] timerQ, timerD;
  logic          errQ, errD;
  logic          inFire, ptWr, ctWr, timedOut;

  logic [SW-1:0] ptBuf [16];
  logic [7:0]    kBuf  [16];
  logic [SW-1:0] ctBuf [16];

  // The same fresh byte is folded into share 0 and share 1, so it cancels in the
  // XOR of all shares; shares are never combined with one another.
  function automatic logic [SW-1:0] remask(input logic [SW-1:0] shares,
                                           input logic [7:0] rnd);
    logic [SW-1:0] r;
    r = shares;
    if (REFRESH != 0) begin
      r[7:0]  = shares[7:0]  ^ rnd;
      r[15:8] = shares[15:8] ^ rnd;
    end
    return r;
  endfunction

  assign InReadyxSO   = ~RstxRI & ((stateQ == IDLE) || (stateQ == LOAD));
  assign inFire       = InValidxSI & InReadyxSO;
  assign timedOut     = ((stateQ == FEED) || (stateQ == RUN)) && (timerQ == TLAST);

  assign CoreStartxSO = (stateQ == FEED) && (idxQ == 4'd0);
  assign CorePTxDO    = (stateQ == FEED) ? ptBuf[idxQ] : '0;
  assign CoreKxDO     = (stateQ == FEED) ? kBuf[idxQ]  : '0;
  assign OutValidxSO  = (stateQ == DRAIN);
  assign CTxDO        = (stateQ == DRAIN) ? ctBuf[idxQ] : '0;
  assign OutLastxSO   = (stateQ == DRAIN) && (idxQ == 4'd15);
  assign ErrxSO       = errQ;

  always_comb begin
    stateD = stateQ;
    idxD   = idxQ;
    timerD = timerQ;
    errD   = errQ;
    ptWr   = 1'b0;
    ctWr   = 1'b0;
    case (stateQ)
      IDLE: begin
        timerD = '0;
        if (inFire) begin
          ptWr   = 1'b1;
          idxD   = idxQ + 4'd1;
          stateD = LOAD;
        end
      end
      LOAD: begin
        timerD = '0;
        if (inFire) begin
          ptWr = 1'b1;
          idxD = idxQ + 4'd1;
          if (idxQ == 4'd15) stateD = FEED;
        end
      end
      FEED: begin
        timerD = timerQ + TONE;
        idxD   = idxQ + 4'd1;
        if (idxQ == 4'd15) stateD = RUN;
        if (timedOut) begin
          errD   = 1'b1;
          idxD   = 4'd0;
          stateD = IDLE;
        end
      end
      RUN: begin
        if (CoreDonexSI) begin
          ctWr   = 1'b1;
          idxD   = idxQ + 4'd1;
          stateD = COLLECT;
        end else if (timedOut) begin
          errD   = 1'b1;
          idxD   = 4'd0;
          stateD = IDLE;
        end else begin
          timerD = timerQ + TONE;
        end
      end
      COLLECT: begin
        // Gaps in the core's done stream simply hold the capture index.
        if (CoreDonexSI) begin
          ctWr = 1'b1;
          idxD = idxQ + 4'd1;
          if (idxQ == 4'd15) stateD = DRAIN;
        end
      end
      DRAIN: begin
        if (OutReadyxSI) begin
          idxD = idxQ + 4'd1;
          if (idxQ == 4'd15) stateD = IDLE;
        end
      end
      default: stateD = IDLE;
    endcase
  end

  always_ff @(posedge ClkxCI or posedge RstxRI) begin
    if (RstxRI) begin
      stateQ <= IDLE;
      idxQ   <= 4'd0;
      timerQ <= '0;
      errQ   <= 1'b0;
    end else begin
      stateQ <= stateD;
      idxQ   <= idxD;
      timerQ <= timerD;
      errQ   <= errD;
    end
  end

  // Data buffers carry no reset; every entry is rewritten before it is read.
  always_ff @(posedge ClkxCI) begin
    if (ptWr) begin
      ptBuf[idxQ] <= remask(PTxDI, RandxDI);
      kBuf[idxQ]  <= KxDI;
    end
    if (ctWr) ctBuf[idxQ] <= CoreCTxDI;
  end

endmodule

// File: tb/tb_aes_ti_seq.sv
// Directed bench: two sequencers (REFRESH=0 and REFRESH=1) share one stimulus stream.
module tb_aes_ti_seq;

  typedef struct {
    logic [7:0] pt0, pt1, key, rnd, expA0, expA1, expB0, expB1;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        inValid = 1'b0;
  logic [15:0] ptIn = '0;
  logic [7:0]  kIn = '0;
  logic [7:0]  rndIn = '0;
  logic        coreDone = 1'b0;
  logic [15:0] coreCT = '0;
  logic        outReady = 1'b1;

  logic        aInReady, aStart, aOutValid, aLast, aErr;
  logic [15:0] aCorePT, aCT;
  logic [7:0]  aCoreK;
  logic        bInReady, bStart, bOutValid, bLast, bErr;
  logic [15:0] bCorePT, bCT;
  logic [7:0]  bCoreK;

  int   errors = 0;
  int   checks = 0;
  vec_t vecs[16];

  always #5 clk = ~clk;

  aes_ti_seq #(.NSHARES(2), .TIMEOUT(20), .REFRESH(0)) dutA (
    .ClkxCI(clk), .RstxRI(rst), .InValidxSI(inValid), .InReadyxSO(aInReady),
    .PTxDI(ptIn), .KxDI(kIn), .RandxDI(rndIn), .CoreStartxSO(aStart),
    .CorePTxDO(aCorePT), .CoreKxDO(aCoreK), .CoreDonexSI(coreDone), .CoreCTxDI(coreCT),
    .OutValidxSO(aOutValid), .OutReadyxSI(outReady), .CTxDO(aCT),
    .OutLastxSO(aLast), .ErrxSO(aErr));

  aes_ti_seq #(.NSHARES(2), .TIMEOUT(20), .REFRESH(1)) dutB (
    .ClkxCI(clk), .RstxRI(rst), .InValidxSI(inValid), .InReadyxSO(bInReady),
    .PTxDI(ptIn), .KxDI(kIn), .RandxDI(rndIn), .CoreStartxSO(bStart),
    .CorePTxDO(bCorePT), .CoreKxDO(bCoreK), .CoreDonexSI(coreDone), .CoreCTxDI(coreCT),
    .OutValidxSO(bOutValid), .OutReadyxSI(outReady), .CTxDO(bCT),
    .OutLastxSO(bLast), .ErrxSO(bErr));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic sendBytes(input int n);
    for (int k = 0; k < n; k++) begin
      inValid  = 1'b1;
      ptIn     = {vecs[k].pt1, vecs[k].pt0};
      kIn      = vecs[k].key;
      rndIn    = vecs[k].rnd;
      coreDone = (k == 5);
      coreCT   = 16'hDEAD;
      chk("in_ready", 32'(aInReady), 32'd1);
      @(negedge clk);
    end
    inValid  = 1'b0;
    coreDone = 1'b0;
  endtask

  task automatic checkFeed();
    for (int k = 0; k < 16; k++) begin
      chk("start_a", 32'(aStart), 32'(k == 0));
      chk("start_b", 32'(bStart), 32'(k == 0));
      chk("core_pt_a", 32'(aCorePT), 32'({vecs[k].expA1, vecs[k].expA0}));
      chk("core_k_a", 32'(aCoreK), 32'(vecs[k].key));
      chk("core_pt_b", 32'(bCorePT), 32'({vecs[k].expB1, vecs[k].expB0}));
      chk("share_xor_b", 32'(bCorePT[7:0] ^ bCorePT[15:8]), 32'(vecs[k].pt0 ^ vecs[k].pt1));
      chk("ready_low_feed", 32'(aInReady), 32'd0);
      @(negedge clk);
    end
    chk("start_after_feed", 32'(aStart), 32'd0);
    chk("core_pt_idle", 32'(aCorePT), 32'd0);
    chk("core_k_idle", 32'(aCoreK), 32'd0);
  endtask

  task automatic collect();
    int   idx = 0;
    logic gap;
    for (int c = 0; c < 19; c++) begin
      gap      = (c == 4) || (c == 9) || (c == 14);
      coreDone = !gap;
      coreCT   = gap ? 16'hEEEE : {8'(8'h30 + idx), 8'(8'hF0 + idx)};
      chk("valid_low_collect", 32'(aOutValid), 32'd0);
      @(negedge clk);
      if (!gap) idx++;
    end
    coreDone = 1'b0;
    coreCT   = 16'h0;
  endtask

  task automatic drain(input bit stall);
    outReady = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (stall && i == 7) begin
        outReady = 1'b0;
        coreDone = 1'b1;
        coreCT   = 16'h5A5A;
        for (int s = 0; s < 5; s++) begin
          chk("stall_valid", 32'(aOutValid), 32'd1);
          chk("stall_ct", 32'(aCT), 32'h37F7);
          chk("stall_last", 32'(aLast), 32'd0);
          @(negedge clk);
        end
        outReady = 1'b1;
        coreDone = 1'b0;
      end
      chk("out_valid", 32'(aOutValid), 32'd1);
      chk("out_ct", 32'(aCT), 32'({8'(8'h30 + i), 8'(8'hF0 + i)}));
      chk("out_last", 32'(aLast), 32'(i == 15));
      @(negedge clk);
    end
    chk("valid_after_drain", 32'(aOutValid), 32'd0);
    chk("last_after_drain", 32'(aLast), 32'd0);
    chk("ready_after_drain", 32'(aInReady), 32'd1);
  endtask

  task automatic runBlock(input bit stall);
    sendBytes(16);
    checkFeed();
    collect();
    drain(stall);
  endtask

  task automatic checkResetOutputs();
    chk("rst_in_ready", 32'(aInReady), 32'd0);
    chk("rst_start", 32'(aStart), 32'd0);
    chk("rst_out_valid", 32'(aOutValid), 32'd0);
    chk("rst_last", 32'(aLast), 32'd0);
    chk("rst_err", 32'(aErr), 32'd0);
    chk("rst_core_pt", 32'(aCorePT), 32'd0);
    chk("rst_core_k", 32'(aCoreK), 32'd0);
    chk("rst_ct", 32'(aCT), 32'd0);
  endtask

  initial begin
    vecs[0]  = '{8'h00, 8'h10, 8'h20, 8'hA5, 8'h00, 8'h10, 8'hA5, 8'hB5};
    vecs[1]  = '{8'h01, 8'h11, 8'h21, 8'hA5, 8'h01, 8'h11, 8'hA4, 8'hB4};
    vecs[2]  = '{8'h02, 8'h12, 8'h22, 8'hA5, 8'h02, 8'h12, 8'hA7, 8'hB7};
    vecs[3]  = '{8'h03, 8'h13, 8'h23, 8'hA5, 8'h03, 8'h13, 8'hA6, 8'hB6};
    vecs[4]  = '{8'h04, 8'h14, 8'h24, 8'hA5, 8'h04, 8'h14, 8'hA1, 8'hB1};
    vecs[5]  = '{8'h05, 8'h15, 8'h25, 8'hA5, 8'h05, 8'h15, 8'hA0, 8'hB0};
    vecs[6]  = '{8'h06, 8'h16, 8'h26, 8'hA5, 8'h06, 8'h16, 8'hA3, 8'hB3};
    vecs[7]  = '{8'h07, 8'h17, 8'h27, 8'hA5, 8'h07, 8'h17, 8'hA2, 8'hB2};
    vecs[8]  = '{8'h08, 8'h18, 8'h28, 8'hA5, 8'h08, 8'h18, 8'hAD, 8'hBD};
    vecs[9]  = '{8'h09, 8'h19, 8'h29, 8'hA5, 8'h09, 8'h19, 8'hAC, 8'hBC};
    vecs[10] = '{8'h0A, 8'h1A, 8'h2A, 8'hA5, 8'h0A, 8'h1A, 8'hAF, 8'hBF};
    vecs[11] = '{8'h0B, 8'h1B, 8'h2B, 8'hA5, 8'h0B, 8'h1B, 8'hAE, 8'hBE};
    vecs[12] = '{8'h0C, 8'h1C, 8'h2C, 8'hA5, 8'h0C, 8'h1C, 8'hA9, 8'hB9};
    vecs[13] = '{8'h0D, 8'h1D, 8'h2D, 8'hA5, 8'h0D, 8'h1D, 8'hA8, 8'hB8};
    vecs[14] = '{8'h0E, 8'h1E, 8'h2E, 8'hA5, 8'h0E, 8'h1E, 8'hAB, 8'hBB};
    vecs[15] = '{8'h0F, 8'h1F, 8'h2F, 8'hA5, 8'h0F, 8'h1F, 8'hAA, 8'hBA};

    // Reset state, then release: ready must rise in the first cycle.
    repeat (2) @(negedge clk);
    checkResetOutputs();
    rst = 1'b0;
    #1;
    chk("ready_after_release", 32'(aInReady), 32'd1);
    @(negedge clk);

    // Full block with done gaps and a 5-cycle output stall at byte 7.
    runBlock(1'b1);

    // Core never answers: error exactly 20 cycles after the start pulse.
    sendBytes(16);
    chk("to_start", 32'(aStart), 32'd1);
    repeat (19) @(negedge clk);
    chk("to_err_early", 32'(aErr), 32'd0);
    chk("to_ready_early", 32'(aInReady), 32'd0);
    @(negedge clk);
    chk("to_err_a", 32'(aErr), 32'd1);
    chk("to_err_b", 32'(bErr), 32'd1);
    chk("to_idle_ready", 32'(aInReady), 32'd1);
    chk("to_no_valid", 32'(aOutValid), 32'd0);

    // Next block still completes and the error stays sticky.
    runBlock(1'b0);
    chk("err_sticky", 32'(aErr), 32'd1);

    // Reset pulse in the middle of loading.
    sendBytes(9);
    rst = 1'b1;
    #1;
    checkResetOutputs();
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("ready_after_midrst", 32'(aInReady), 32'd1);

    // Fresh block; byte 0 carries the remask example 01/02 with 0xA5.
    vecs[0] = '{8'h01, 8'h02, 8'h20, 8'hA5, 8'h01, 8'h02, 8'hA4, 8'hA7};
    runBlock(1'b0);
    chk("err_cleared", 32'(aErr), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
